// File: rtl/gamepad_input_decoder_if.sv
// ============================================================================
// Module   : gamepad_input_decoder_if
// Brief    : Pad pins plus the decoded edge/state bus of one gamepad decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gamepad_input_decoder_if;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [9:0] input_data;
  logic [4:0] pad_state;
  logic       poll_done;

  modport master (
    input  pad_data,
    output pad_latch,
    output pad_clk,
    output input_data,
    output pad_state,
    output poll_done
  );

  modport slave (
    output pad_data,
    input  pad_latch,
    input  pad_clk,
    input  input_data,
    input  pad_state,
    input  poll_done
  );
endinterface

`default_nettype wire

// File: rtl/gamepad_input_decoder.sv
// ============================================================================
// Module   : gamepad_input_decoder
// Brief    : Polls an NES-style serial pad and emits press/release edge words.
//            Define GAMEPAD_DEBOUNCE_EN to require two matching polls per commit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gamepad_input_decoder #(
  parameter int CLK_DIV     = 6,
  parameter int POLL_PERIOD = 4096
) (
  input  wire logic                    clk,
  input  wire logic                    reset,
  gamepad_input_decoder_if.master      pad
);

  localparam int CNT_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(POLL_PERIOD - 1);
  localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_LATCH    = 3'd1;
  localparam logic [2:0] c_SHIFT_LO = 3'd2;
  localparam logic [2:0] c_SHIFT_HI = 3'd3;
  localparam logic [2:0] c_UPDATE   = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_pad_latch;
  logic             r_pad_clk;
  logic [9:0]       r_input_data;
  logic [4:0]       r_pad_state;
  logic             r_poll_done;

  logic             w_poll_start;
  logic             w_phase_end;
  logic [4:0]       w_new;
  logic             w_commit;
  logic             w_unused_shift;

  assign w_poll_start   = (r_cnt == c_CNT_LAST);
  assign w_phase_end    = (r_div == c_DIV_LAST);
  // Serial order is A,B,Sel,Start,Up,Down,Left,Right; repack as {A,R,L,D,U}.
  assign w_new          = {r_shift[0], r_shift[7], r_shift[6], r_shift[5], r_shift[4]};
  assign w_unused_shift = ^r_shift[3:1];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:     if (w_poll_start) w_state_nxt = c_LATCH;
      c_LATCH:    if (w_phase_end)  w_state_nxt = c_SHIFT_LO;
      c_SHIFT_LO: if (w_phase_end)  w_state_nxt = (r_bit_idx == 3'd7) ? c_UPDATE : c_SHIFT_HI;
      c_SHIFT_HI: if (w_phase_end)  w_state_nxt = c_SHIFT_LO;
      c_UPDATE:                     w_state_nxt = c_IDLE;
      default:                      w_state_nxt = c_IDLE;
    endcase
  end

`ifdef GAMEPAD_DEBOUNCE_EN
  logic [4:0] r_raw;

  assign w_commit = (w_new == r_raw);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_raw <= '0;
    end else if (r_state == c_UPDATE) begin
      r_raw <= w_new;
    end
  end
`else
  assign w_commit = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= c_IDLE;
      r_cnt        <= '0;
      r_div        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_pad_latch  <= 1'b0;
      r_pad_clk    <= 1'b0;
      r_input_data <= '0;
      r_pad_state  <= '0;
      r_poll_done  <= 1'b0;
    end else begin
      r_cnt       <= w_poll_start ? '0 : r_cnt + 1'b1;
      r_state     <= w_state_nxt;
      r_div       <= ((w_state_nxt != r_state) || (r_state == c_IDLE)) ? '0 : r_div + 1'b1;
      // Pin strobes follow the next state so they are glitch-free flops.
      r_pad_latch <= (w_state_nxt == c_LATCH);
      r_pad_clk   <= (w_state_nxt == c_SHIFT_HI);

      r_input_data <= '0;
      r_poll_done  <= 1'b0;

      if (r_state == c_SHIFT_LO && w_phase_end) begin
        r_shift[r_bit_idx] <= ~pad.pad_data;
      end
      if (r_state == c_SHIFT_HI && w_phase_end) begin
        r_bit_idx <= r_bit_idx + 1'b1;
      end

      if (r_state == c_UPDATE) begin
        r_bit_idx   <= '0;
        r_poll_done <= 1'b1;
        if (w_commit) begin
          r_input_data <= {w_new & ~r_pad_state, ~w_new & r_pad_state};
          r_pad_state  <= w_new;
        end
      end
    end
  end

  assign pad.pad_latch  = r_pad_latch;
  assign pad.pad_clk    = r_pad_clk;
  assign pad.input_data = r_input_data;
  assign pad.pad_state  = r_pad_state;
  assign pad.poll_done  = r_poll_done;

endmodule

`default_nettype wire

// File: tb/tb_gamepad_input_decoder.sv
// ============================================================================
// Module   : tb_gamepad_input_decoder
// Brief    : Self-checking bench; a behavioural NES pad drives the serial line.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gamepad_input_decoder;

  logic clk;
  logic reset;

  gamepad_input_decoder_if pif ();

  gamepad_input_decoder #(
    .CLK_DIV     (2),
    .POLL_PERIOD (64)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .pad   (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pad model: buttons indexed in serial order A,B,Sel,Start,Up,Down,Left,Right.
  logic [7:0] btn;
  int         pidx;
  logic       prev_pclk;

  always @(posedge clk) begin
    prev_pclk <= pif.pad_clk;
    if (pif.pad_latch)
      pidx <= 0;
    else if (pif.pad_clk && !prev_pclk)
      pidx <= pidx + 1;
  end

  always_comb begin
    pif.pad_data = 1'b1;
    if (pidx >= 0 && pidx < 8)
      pif.pad_data = ~btn[pidx[2:0]];
  end

  int checks;
  int failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_poll(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pif.poll_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL poll_timeout: got no poll_done expected pulse within 200 cycles");
    end
  endtask

  typedef struct {
    logic [7:0] btn;
    logic [9:0] exp_data;
    logic [4:0] exp_state;
  } vec_t;

`ifdef GAMEPAD_DEBOUNCE_EN
  localparam int NVEC = 7;
`else
  localparam int NVEC = 10;
`endif
  vec_t vecs [NVEC];

  initial begin
    bit ok;
    checks    = 0;
    failures  = 0;
    btn       = 8'h00;
    pidx      = 8;
    prev_pclk = 1'b0;

`ifdef GAMEPAD_DEBOUNCE_EN
    vecs[0] = '{8'b0000_0001, 10'b00000_00000, 5'b00000};  // A once: held off
    vecs[1] = '{8'b0000_0000, 10'b00000_00000, 5'b00000};  // glitch rejected
    vecs[2] = '{8'b0000_0001, 10'b00000_00000, 5'b00000};
    vecs[3] = '{8'b0000_0001, 10'b10000_00000, 5'b10000};  // second matching poll
    vecs[4] = '{8'b0000_0001, 10'b00000_00000, 5'b10000};
    vecs[5] = '{8'b0000_0000, 10'b00000_00000, 5'b10000};
    vecs[6] = '{8'b0000_0000, 10'b00000_10000, 5'b00000};
`else
    vecs[0] = '{8'b0001_0001, 10'b10001_00000, 5'b10001};  // A + Up
    vecs[1] = '{8'b0001_0001, 10'b00000_00000, 5'b10001};  // no change
    vecs[2] = '{8'b1001_0000, 10'b01000_10000, 5'b01001};  // drop A, add Right
    vecs[3] = '{8'b0000_0000, 10'b00000_01001, 5'b00000};
    vecs[4] = '{8'b0000_1110, 10'b00000_00000, 5'b00000};  // B/Sel/Start ignored
    vecs[5] = '{8'b0000_1110, 10'b00000_00000, 5'b00000};
    vecs[6] = '{8'b0110_0000, 10'b00110_00000, 5'b00110};  // Left + Down
    vecs[7] = '{8'b0011_0000, 10'b00001_00100, 5'b00011};  // Up+Down together
    vecs[8] = '{8'b1111_0001, 10'b11100_00000, 5'b11111};
    vecs[9] = '{8'b0000_0000, 10'b00000_11111, 5'b00000};
`endif

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_latch", 32'(pif.pad_latch), 32'd0);
    chk("rst_pclk",  32'(pif.pad_clk),   32'd0);
    chk("rst_data",  32'(pif.input_data), 32'd0);
    chk("rst_state", 32'(pif.pad_state), 32'd0);
    chk("rst_done",  32'(pif.poll_done), 32'd0);

    // First poll timing, idle pad
    reset = 1'b0;
    for (int c = 1; c <= 98; c++) begin
      @(negedge clk);
      if (c >= 63 && c <= 66)
        chk($sformatf("latch_c%0d", c), 32'(pif.pad_latch), 32'((c == 64) || (c == 65)));
      if (c >= 66 && c <= 73)
        chk($sformatf("pclk_c%0d", c), 32'(pif.pad_clk), 32'(((c - 66) / 2) % 2));
      if (c >= 96)
        chk($sformatf("done_c%0d", c), 32'(pif.poll_done), 32'(c == 97));
      if (c == 97) begin
        chk("idle_data",  32'(pif.input_data), 32'd0);
        chk("idle_state", 32'(pif.pad_state),  32'd0);
      end
    end

    // Table-driven polls
    for (int v = 0; v < NVEC; v++) begin
      btn = vecs[v].btn;
      wait_poll(ok);
      if (ok) begin
        chk($sformatf("vec%0d_data", v),  32'(pif.input_data), 32'(vecs[v].exp_data));
        chk($sformatf("vec%0d_state", v), 32'(pif.pad_state),  32'(vecs[v].exp_state));
        @(negedge clk);
        chk($sformatf("vec%0d_pulse", v), 32'({pif.poll_done, pif.input_data}), 32'd0);
      end
    end

    // Hold Up until it is committed, then reset during SHIFT_HI of bit 3
    btn = 8'b0001_0000;
    wait_poll(ok);
`ifdef GAMEPAD_DEBOUNCE_EN
    wait_poll(ok);
`endif
    chk("up_state", 32'(pif.pad_state), 32'b00001);
    repeat (47) @(negedge clk);
    chk("mid_pclk",  32'(pif.pad_clk),   32'd1);
    chk("mid_state", 32'(pif.pad_state), 32'b00001);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_latch", 32'(pif.pad_latch),  32'd0);
    chk("abort_pclk",  32'(pif.pad_clk),    32'd0);
    chk("abort_data",  32'(pif.input_data), 32'd0);
    chk("abort_state", 32'(pif.pad_state),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_poll(ok);
`ifdef GAMEPAD_DEBOUNCE_EN
    if (ok) chk("post_rst_hold", 32'(pif.input_data), 32'd0);
    wait_poll(ok);
`endif
    if (ok) begin
      chk("post_rst_data",  32'(pif.input_data), 32'(10'b00001_00000));
      chk("post_rst_state", 32'(pif.pad_state),  32'b00001);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
